// File: rtl/fp32_pkg.sv
// Shared FP32 constants and types for the adder's normalise/round stage.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [7:0]  INF_EXP  = 8'hFF;

  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_UNF  = 2'd2
  } kind_t;

endpackage

// File: rtl/lzd24_count.sv
// Leading-zero count of a 24-bit vector; 24 when the input is all zero.
module lzd24_count (
  input  logic [23:0] in,
  output logic [4:0]  out
);

  // Ascending scan: the highest set bit is the last writer and wins.
  always_comb begin
    out = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (in[i]) out = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_norm_round.sv
// FP32 adder post-add stage: normalise (stage 1), round-to-nearest-even and pack (stage 2).
module fp32_norm_round
  import fp32_pkg::*;
#(
  parameter int EXP_W  = fp32_pkg::EXP_W,
  parameter int MANT_W = fp32_pkg::MANT_W,
  parameter int BIAS   = fp32_pkg::BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W:0]   in_mant,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  logic               s1_valid;
  kind_t              s1_kind;
  logic               s1_sign;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_mant;
  logic               s1_g, s1_r, s1_s;

  logic               s2_load;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1: normalise
  logic [4:0]         lz;
  logic [25:0]        sh;
  kind_t              n_kind;
  logic signed [9:0]  n_exp;
  logic [23:0]        n_mant;
  logic               n_g, n_r, n_s;

  lzd24_count u_lzd (
    .in  (in_mant[23:0]),
    .out (lz)
  );

  assign sh = {in_mant[23:0], in_grs[2], in_grs[1]} << lz;

  always_comb begin
    n_kind = K_NORM;
    n_exp  = '0;
    n_mant = '0;
    n_g    = 1'b0;
    n_r    = 1'b0;
    n_s    = 1'b0;
    if (in_mant == '0 && in_grs == '0) begin
      n_kind = K_ZERO;
    end else if (in_mant[24]) begin
      n_mant = in_mant[24:1];
      n_g    = in_mant[0];
      n_r    = in_grs[2];
      n_s    = in_grs[1] | in_grs[0];
      n_exp  = signed'({2'b00, in_exp}) + 10'sd1;
    end else if (lz == 5'd24 || {5'b00000, lz} >= {2'b00, in_exp}) begin
      n_kind = K_UNF;
    end else begin
      n_mant = sh[25:2];
      n_g    = sh[1];
      n_r    = sh[0];
      n_s    = in_grs[0];
      n_exp  = signed'({2'b00, in_exp}) - signed'({5'b00000, lz});
    end
  end

  // Stage 2: round and pack
  logic               rnd;
  logic               inexact;
  logic signed [9:0]  r_exp;
  logic [22:0]        r_frac;
  logic [31:0]        r_result;
  logic [3:0]         r_flags;

  always_comb begin
    rnd     = s1_g & (s1_r | s1_s | s1_mant[0]);
    inexact = s1_g | s1_r | s1_s;
    r_frac  = s1_mant[22:0] + 23'(rnd);
    r_exp   = s1_exp;
    if (rnd && s1_mant == 24'hFF_FFFF) r_exp = s1_exp + 10'sd1;

    r_result = POS_ZERO;
    r_flags  = '0;
    unique case (s1_kind)
      K_ZERO: r_flags[FLAG_ZERO] = 1'b1;
      K_UNF: begin
        r_result[SIGN_BIT] = s1_sign;
        r_flags[FLAG_UNF]  = 1'b1;
        r_flags[FLAG_INX]  = 1'b1;
      end
      default: begin
        r_result[SIGN_BIT] = s1_sign;
        if (r_exp >= signed'(10'(2 * BIAS + 1))) begin
          r_result[EXP_HI:EXP_LO] = INF_EXP;
          r_flags[FLAG_OVF]       = 1'b1;
          r_flags[FLAG_INX]       = 1'b1;
        end else begin
          r_result[EXP_HI:EXP_LO]   = r_exp[7:0];
          r_result[FRAC_HI:FRAC_LO] = r_frac;
          r_flags[FLAG_INX]         = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_kind    <= K_NORM;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_mant    <= '0;
      s1_g       <= 1'b0;
      s1_r       <= 1'b0;
      s1_s       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= r_result;
          out_flags  <= r_flags;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_kind <= n_kind;
          s1_sign <= in_sign;
          s1_exp  <= n_exp;
          s1_mant <= n_mant;
          s1_g    <= n_g;
          s1_r    <= n_r;
          s1_s    <= n_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Directed bench for fp32_norm_round: single beats, backpressure streaming and mid-flight reset.
module tb_fp32_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_norm_round #(.EXP_W(8), .MANT_W(24), .BIAS(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_grs     (in_grs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [2:0] g);
    in_sign = s;
    in_exp  = e;
    in_mant = m;
    in_grs  = g;
  endtask

  task automatic single(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [2:0] g, input logic [31:0] eres, input logic [3:0] eflg);
    @(posedge clk); #1;
    drive(s, e, m, g);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " result"}, out_result, eres);
    chk({tag, " flags"}, 32'(out_flags), 32'(eflg));
  endtask

  logic        bs[4];
  logic [7:0]  be[4];
  logic [24:0] bm[4];
  logic [2:0]  bg[4];
  logic [31:0] br[4];
  logic [3:0]  bf[4];

  initial begin
    int sent, recv;
    logic fire;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'd0, 25'd0, 3'd0);
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_flags", 32'(out_flags), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    single("carry",   1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 4'b0000);
    single("cancel",  1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 4'b0000);
    single("tie_up",  1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 4'b0010);
    single("tie_dn",  1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 4'b0010);
    single("rnd_cry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h40000000, 4'b0010);
    single("ovf",     1'b0, 8'd254, 25'h1FFFFFE, 3'b000, 32'h7F800000, 4'b1010);
    single("unf",     1'b1, 8'd5,   25'h0000010, 3'b000, 32'h80000000, 4'b0110);
    single("zero",    1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 4'b0001);
    single("neg",     1'b1, 8'd130, 25'h0C00000, 3'b011, 32'hC1400000, 4'b0010);

    bs = '{1'b0, 1'b0, 1'b0, 1'b1};
    be = '{8'd127, 8'd127, 8'd127, 8'd5};
    bm = '{25'h1000000, 25'h0000001, 25'h0800001, 25'h0000010};
    bg = '{3'b000, 3'b000, 3'b100, 3'b000};
    br = '{32'h40000000, 32'h34000000, 32'h3F800002, 32'h80000000};
    bf = '{4'b0000, 4'b0000, 4'b0010, 4'b0110};
    sent = 0; recv = 0; held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) drive(bs[sent], be[sent], bm[sent], bg[sent]);
      #1;
      if (cyc == 2) begin
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        chk("bp stall valid", 32'(out_valid), 32'd1);
        held = out_result;
      end
      if (cyc == 3 || cyc == 4) begin
        chk("bp stall stable", out_result, held);
        chk("bp stall in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        chk("bp order result", out_result, br[recv]);
        chk("bp order flags", 32'(out_flags), 32'(bf[recv]));
        recv++;
      end
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
    end
    in_valid = 1'b0;
    chk("bp received", 32'(recv), 32'd4);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp no dup", 32'(out_valid), 32'd0);
    end

    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 8'd127, 25'h1000000, 3'b000);
    @(posedge clk); #1;
    drive(1'b0, 8'd127, 25'h0000001, 3'b000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid both valid", 32'(out_valid), 32'd1);
    chk("mid in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst result", out_result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post rst idle", 32'(out_valid), 32'd0);
    single("post_rst", 1'b1, 8'd5, 25'h0000010, 3'b000, 32'h80000000, 4'b0110);
    @(posedge clk); #1;
    chk("post rst drain", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
